// File: rtl/record_sequencer_pkg.sv
// Shared field widths, state encoding and sizing helpers for the note record sequencer.
package record_sequencer_pkg;

  localparam int unsigned OctaveBits        = 3;
  localparam int unsigned NoteBits          = 3;
  localparam int unsigned LengthBits        = 3;
  localparam int unsigned FullNoteBits      = 3;
  localparam int unsigned RecCntBitsDefault = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StLoad   = 2'd2,
    StHold   = 2'd3
  } seq_state_e;

  localparam logic [OctaveBits-1:0]   PlayOctaveRst   = 3'b100;
  localparam logic [FullNoteBits-1:0] PlayFullNoteRst = 3'b100;

  // One spare bit so 8 * tick_cycles itself is representable during the load multiply.
  function automatic int unsigned hold_cnt_bits(input int unsigned tick_cycles);
    return $clog2(8 * tick_cycles) + 1;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter with zero flag; times how long the current note sounds.
module note_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !zero) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/record_sequencer.sv
// Records note entries into an external store, then plays them back one by one,
// holding each note for (length+1) ticks plus one load cycle.
module record_sequencer
  import record_sequencer_pkg::*;
#(
  parameter int unsigned REC_CNT_BITS = RecCntBitsDefault,
  parameter int unsigned TICK_CYCLES  = 12500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_rec,
  input  logic                    start_play,
  input  logic                    stop,
  input  logic                    note_valid,
  input  logic [OctaveBits-1:0]   in_octave,
  input  logic [NoteBits-1:0]     in_note,
  input  logic [LengthBits-1:0]   in_length,
  input  logic [FullNoteBits-1:0] in_full_note,
  output logic                    mem_en,
  output logic                    mem_rw,
  output logic [REC_CNT_BITS-1:0] mem_cnt,
  output logic [OctaveBits-1:0]   mem_octave,
  output logic [NoteBits-1:0]     mem_note,
  output logic [LengthBits-1:0]   mem_length,
  output logic [FullNoteBits-1:0] mem_full_note,
  input  logic [OctaveBits-1:0]   rd_octave,
  input  logic [NoteBits-1:0]     rd_note,
  input  logic [LengthBits-1:0]   rd_length,
  input  logic [FullNoteBits-1:0] rd_full_note,
  output logic                    play_valid,
  output logic [OctaveBits-1:0]   play_octave,
  output logic [NoteBits-1:0]     play_note,
  output logic [FullNoteBits-1:0] play_full_note,
  output logic [1:0]              state,
  output logic [REC_CNT_BITS:0]   rec_len,
  output logic                    done
);

  localparam int unsigned HoldW = hold_cnt_bits(TICK_CYCLES);
  localparam logic [HoldW-1:0] TickW = HoldW'(TICK_CYCLES);
  localparam logic [REC_CNT_BITS:0] LenOne = 1;
  localparam logic [REC_CNT_BITS-1:0] PtrOne = 1;
  localparam logic [REC_CNT_BITS:0] RecMax = {1'b1, {REC_CNT_BITS{1'b0}}};

  seq_state_e              state_q;
  logic [REC_CNT_BITS-1:0] wr_ptr_q;
  logic [REC_CNT_BITS-1:0] rd_ptr_q;

  logic             timer_load;
  logic             timer_dec;
  logic             timer_zero;
  logic [HoldW-1:0] hold_len;
  logic [HoldW-1:0] hold_val;
  logic [REC_CNT_BITS:0] rd_next_len;

  // The store answers combinationally at mem_cnt, which equals rd_ptr throughout LOAD.
  assign hold_len    = HoldW'(rd_length) + HoldW'(1);
  assign hold_val    = hold_len * TickW - HoldW'(1);
  assign timer_load  = (state_q == StLoad) && !stop;
  assign timer_dec   = (state_q == StHold);
  assign rd_next_len = {1'b0, rd_ptr_q} + LenOne;
  assign state       = state_q;

  note_timer #(
    .Width (HoldW)
  ) u_note_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (hold_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rec_len        <= '0;
      mem_en         <= 1'b0;
      mem_rw         <= 1'b0;
      mem_cnt        <= '0;
      mem_octave     <= '0;
      mem_note       <= '0;
      mem_length     <= '0;
      mem_full_note  <= '0;
      play_valid     <= 1'b0;
      play_octave    <= PlayOctaveRst;
      play_note      <= '0;
      play_full_note <= PlayFullNoteRst;
      done           <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_rw <= 1'b0;
      done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_rec) begin
            rec_len  <= '0;
            wr_ptr_q <= '0;
            state_q  <= StRecord;
          end else if (start_play) begin
            if (rec_len != '0) begin
              rd_ptr_q <= '0;
              mem_en   <= 1'b1;
              mem_cnt  <= '0;
              state_q  <= StLoad;
            end else begin
              done <= 1'b1;
            end
          end
        end
        StRecord: begin
          if (note_valid) begin
            mem_octave    <= in_octave;
            mem_note      <= in_note;
            mem_length    <= in_length;
            mem_full_note <= in_full_note;
            mem_en        <= 1'b1;
            mem_rw        <= 1'b1;
            mem_cnt       <= wr_ptr_q;
            wr_ptr_q      <= wr_ptr_q + PtrOne;
            rec_len       <= rec_len + LenOne;
            // Store full: stop before the pointer could wrap onto entry 0.
            if (rec_len + LenOne == RecMax) begin
              state_q <= StIdle;
            end
          end
          if (stop) begin
            state_q <= StIdle;
          end
        end
        StLoad: begin
          if (stop) begin
            play_valid <= 1'b0;
            state_q    <= StIdle;
          end else begin
            play_octave    <= rd_octave;
            play_note      <= rd_note;
            play_full_note <= rd_full_note;
            play_valid     <= 1'b1;
            state_q        <= StHold;
          end
        end
        StHold: begin
          if (stop) begin
            play_valid <= 1'b0;
            state_q    <= StIdle;
          end else if (timer_zero) begin
            play_valid <= 1'b0;
            if (rd_next_len == rec_len) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              rd_ptr_q <= rd_ptr_q + PtrOne;
              mem_en   <= 1'b1;
              mem_cnt  <= rd_ptr_q + PtrOne;
              state_q  <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_record_sequencer.sv
// Scoreboard bench: stimulus queues expected store writes, reads and play windows;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_record_sequencer;

  localparam int unsigned RecBits = 2;
  localparam int unsigned Tick    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_rec = 1'b0, start_play = 1'b0, stop = 1'b0, note_valid = 1'b0;
  logic [2:0] in_octave = '0, in_note = '0, in_length = '0, in_full_note = '0;
  logic mem_en, mem_rw;
  logic [RecBits-1:0] mem_cnt;
  logic [2:0] mem_octave, mem_note, mem_length, mem_full_note;
  logic [2:0] rd_octave, rd_note, rd_length, rd_full_note;
  logic play_valid;
  logic [2:0] play_octave, play_note, play_full_note;
  logic [1:0] state;
  logic [RecBits:0] rec_len;
  logic done;

  always #5 clk = ~clk;

  record_sequencer #(
    .REC_CNT_BITS (RecBits),
    .TICK_CYCLES  (Tick)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_rec      (start_rec),
    .start_play     (start_play),
    .stop           (stop),
    .note_valid     (note_valid),
    .in_octave      (in_octave),
    .in_note        (in_note),
    .in_length      (in_length),
    .in_full_note   (in_full_note),
    .mem_en         (mem_en),
    .mem_rw         (mem_rw),
    .mem_cnt        (mem_cnt),
    .mem_octave     (mem_octave),
    .mem_note       (mem_note),
    .mem_length     (mem_length),
    .mem_full_note  (mem_full_note),
    .rd_octave      (rd_octave),
    .rd_note        (rd_note),
    .rd_length      (rd_length),
    .rd_full_note   (rd_full_note),
    .play_valid     (play_valid),
    .play_octave    (play_octave),
    .play_note      (play_note),
    .play_full_note (play_full_note),
    .state          (state),
    .rec_len        (rec_len),
    .done           (done)
  );

  typedef struct {int cnt; logic [11:0] f;} wr_t;
  typedef struct {logic [8:0] f; int len; int gap;} win_t;

  wr_t  wr_q[$];
  int   rd_q[$];
  win_t win_q[$];
  int   n_cmp = 0, n_fail = 0, done_seen = 0, done_exp = 0;

  // External store model, read combinationally at mem_cnt.
  logic [11:0] store [4];
  assign {rd_octave, rd_note, rd_length, rd_full_note} = store[mem_cnt];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexp(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected event, value 0x%0h, expected none at %0t", name, act, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int cnt, input logic [2:0] o, n, l, f);
    wr_t e;
    e.cnt = cnt;
    e.f   = {o, n, l, f};
    wr_q.push_back(e);
  endtask

  task automatic push_win(input logic [2:0] o, n, f, input int len, input int gap);
    win_t e;
    e.f   = {o, n, f};
    e.len = len;
    e.gap = gap;
    win_q.push_back(e);
  endtask

  task automatic rec_note(input logic [2:0] o, n, l, f);
    in_octave = o; in_note = n; in_length = l; in_full_note = f;
    note_valid = 1'b1;
    cyc();
    note_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(0));
    chk({tag, "_rec_len"}, 32'(rec_len), 32'(0));
    chk({tag, "_mem_ctl"}, 32'({mem_en, mem_rw, mem_cnt}), 32'(0));
    chk({tag, "_mem_data"}, 32'({mem_octave, mem_note, mem_length, mem_full_note}), 32'(0));
    chk({tag, "_play"}, 32'({play_valid, play_octave, play_note, play_full_note}),
        32'({1'b0, 3'b100, 3'b000, 3'b100}));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // Monitor
  wr_t        mon_wr;
  win_t       mon_win;
  int         mon_rd;
  logic       prev_pv = 1'b0;
  int         win_len = 0, gap_cnt = 0;
  logic [8:0] cap;

  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_rw === 1'b1) begin
      store[mem_cnt] = {mem_octave, mem_note, mem_length, mem_full_note};
      if (wr_q.size() == 0) begin
        unexp("write", 32'({mem_cnt, mem_octave, mem_note, mem_length, mem_full_note}));
      end else begin
        mon_wr = wr_q.pop_front();
        chk("write", 32'({mem_cnt, mem_octave, mem_note, mem_length, mem_full_note}),
            32'({mon_wr.cnt[RecBits-1:0], mon_wr.f}));
      end
    end
    if (mem_en === 1'b1 && mem_rw === 1'b0) begin
      if (rd_q.size() == 0) begin
        unexp("read", 32'(mem_cnt));
      end else begin
        mon_rd = rd_q.pop_front();
        chk("read_cnt", 32'(mem_cnt), 32'(mon_rd));
      end
    end
    if (done === 1'b1) done_seen++;
    if (play_valid === 1'b1) begin
      if (!prev_pv) begin
        cap     = {play_octave, play_note, play_full_note};
        win_len = 1;
        if (win_q.size() == 0) unexp("play_start", 32'(cap));
        else if (win_q[0].gap != 0) chk("load_gap", 32'(gap_cnt), 32'(win_q[0].gap));
      end else begin
        win_len++;
      end
    end else begin
      if (prev_pv) begin
        if (win_q.size() != 0) begin
          mon_win = win_q.pop_front();
          chk("play_window", 32'({cap, win_len[7:0]}), 32'({mon_win.f, mon_win.len[7:0]}));
        end
        gap_cnt = 1;
      end else begin
        gap_cnt++;
      end
    end
    prev_pv = (play_valid === 1'b1);
  end

  initial begin
    for (int i = 0; i < 4; i++) store[i] = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    cyc();

    // Play with nothing recorded: immediate done, no store access.
    start_play = 1'b1; cyc(); start_play = 1'b0;
    done_exp++;
    @(negedge clk);
    chk("empty_play_done", 32'(done), 32'(1));
    chk("empty_play_state", 32'(state), 32'(0));
    chk("empty_play_mem_en", 32'(mem_en), 32'(0));
    cyc();

    // Record three notes then stop.
    push_wr(0, 3'd4, 3'd1, 3'd0, 3'd2);
    push_wr(1, 3'd5, 3'd3, 3'd1, 3'd5);
    push_wr(2, 3'd3, 3'd7, 3'd2, 3'd1);
    start_rec = 1'b1; cyc(); start_rec = 1'b0;
    @(negedge clk);
    chk("rec_state", 32'(state), 32'(1));
    cyc();
    rec_note(3'd4, 3'd1, 3'd0, 3'd2);
    rec_note(3'd5, 3'd3, 3'd1, 3'd5);
    rec_note(3'd3, 3'd7, 3'd2, 3'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    @(negedge clk);
    chk("rec3_state", 32'(state), 32'(0));
    chk("rec3_len", 32'(rec_len), 32'(3));
    cyc();

    // Full playback: windows 4/8/12 with single-cycle loads between them.
    rd_q.push_back(0); rd_q.push_back(1); rd_q.push_back(2);
    push_win(3'd4, 3'd1, 3'd2, 4, 0);
    push_win(3'd5, 3'd3, 3'd5, 8, 1);
    push_win(3'd3, 3'd7, 3'd1, 12, 1);
    done_exp++;
    start_play = 1'b1; cyc(); start_play = 1'b0;
    repeat (35) cyc();
    @(negedge clk);
    chk("play_end_state", 32'(state), 32'(0));
    chk("play_done_count", 32'(done_seen), 32'(done_exp));

    // Stop during the second note's hold.
    rd_q.push_back(0); rd_q.push_back(1);
    push_win(3'd4, 3'd1, 3'd2, 4, 0);
    push_win(3'd5, 3'd3, 3'd5, 3, 1);
    cyc();
    start_play = 1'b1; cyc(); start_play = 1'b0;
    repeat (8) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    @(negedge clk);
    chk("stop_play_valid", 32'(play_valid), 32'(0));
    chk("stop_state", 32'(state), 32'(0));
    repeat (3) cyc();
    chk("stop_no_done", 32'(done_seen), 32'(done_exp));

    // start_rec wins over start_play.
    start_rec = 1'b1; start_play = 1'b1; cyc(); start_rec = 1'b0; start_play = 1'b0;
    @(negedge clk);
    chk("both_start_state", 32'(state), 32'(1));
    stop = 1'b1; cyc(); stop = 1'b0;

    // Five notes into a four-entry store: only four writes, auto-return to idle.
    for (int i = 0; i < 4; i++) push_wr(i, 3'(i + 1), 3'(6 - i), 3'(i + 1), 3'(i));
    start_rec = 1'b1; cyc(); start_rec = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_octave = 3'(i + 1); in_note = 3'(6 - i); in_length = 3'(i + 1); in_full_note = 3'(i);
      note_valid = 1'b1;
      cyc();
    end
    note_valid = 1'b0;
    @(negedge clk);
    chk("full_state", 32'(state), 32'(0));
    chk("full_len", 32'(rec_len), 32'(4));
    cyc();

    // Reset in the middle of the first note's hold.
    rd_q.push_back(0);
    push_win(3'd1, 3'd6, 3'd0, 2, 0);
    start_play = 1'b1; cyc(); start_play = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    cyc();

    // Stored entries are forgotten after reset.
    done_exp++;
    start_play = 1'b1; cyc(); start_play = 1'b0;
    @(negedge clk);
    chk("post_reset_done", 32'(done), 32'(1));
    repeat (3) cyc();

    chk("done_total", 32'(done_seen), 32'(done_exp));
    chk("wr_q_left", 32'(wr_q.size()), 32'(0));
    chk("rd_q_left", 32'(rd_q.size()), 32'(0));
    chk("win_q_left", 32'(win_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
